// File: rtl/aes_input_packer_pkg.sv
// sysdef: shared AES ingress types and constants
package sysdef;
  localparam int AES_HOST_W = 32;
  localparam int AES_WORDS_PER_BLK = 4;
  typedef struct packed {
    logic                                    valid;
    logic                                    set_key;
    logic [AES_HOST_W*AES_WORDS_PER_BLK-1:0] data;
  } in_packet_t;
  typedef enum logic [0:0] {ASSEMBLE, DROP} packer_state_t;
endpackage

// File: rtl/aes_input_packer_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with flush, count/full/empty
module sync_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-2:0] wptr, rptr;
  logic do_push, do_pop;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = mem[rptr];
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wptr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
endmodule

// File: rtl/aes_input_packer.sv
// aes_input_packer: assembles 4 host words into tagged 128-bit blocks and queues them for the AES controller
module aes_input_packer import sysdef::*; #(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [AES_HOST_W-1:0] host_data,
  input  logic                  host_set_key,
  input  logic                  host_last,
  input  logic                  load_data,
  output in_packet_t            pkt_out,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  err_frame
);
  localparam logic [1:0] LAST_IDX = 2'(AES_WORDS_PER_BLK - 1);
  packer_state_t state;
  logic [1:0] idx;
  logic [0:2][AES_HOST_W-1:0] stg;
  logic sk, xfer, asm, at_last, push, full, empty;
  logic [128:0] fifo_q;
  assign asm = state == ASSEMBLE;
  assign at_last = idx == LAST_IDX;
  // Ready only drops for the closing word, so a pop is needed before the block can commit
  assign host_ready = ~(asm & at_last & full);
  assign xfer = host_valid & host_ready;
  assign push = xfer & ~flush & asm & at_last & host_last;
  assign pkt_out = empty ? '0 : in_packet_t'{valid: 1'b1, set_key: fifo_q[128], data: fifo_q[127:0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ASSEMBLE;
      idx <= '0;
      stg <= '0;
      sk <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      err_frame <= xfer & ~flush & asm & (at_last ^ host_last);
      if (flush) begin
        state <= ASSEMBLE;
        idx <= '0;
        stg <= '0;
        sk <= 1'b0;
      end else if (xfer) begin
        if (!asm) state <= host_last ? ASSEMBLE : DROP;
        else if (at_last || host_last) begin
          idx <= '0;
          if (!host_last) state <= DROP;
        end else begin
          stg[idx] <= host_data;
          idx <= idx + 1'b1;
          if (idx == '0) sk <= host_set_key;
        end
      end
    end
  sync_fifo #(.WIDTH(129), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (load_data),
    .wdata ({sk, stg, host_data}),
    .rdata (fifo_q),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );
endmodule
